// File: rtl/pipeline_scale_mask_pkg.sv
// Shared types for pipeline_scale_mask: FSM state encoding and the causal-mask fill value.
package pipeline_scale_mask_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PROC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Most negative value at the default 16-bit element width.
  localparam logic [15:0] MASK_VAL = 16'h8000;

endpackage

// File: rtl/pipeline_scale_mask_row_max_scale.sv
// Combinational single-row datapath: arithmetic scale, optional causal mask (CAUSAL_MASK_EN), signed row max.
module row_max_scale #(
  parameter int D_W         = 16,
  parameter int SA_R        = 16,
  parameter int SA_C        = 16,
  parameter int SCALE_SHIFT = 2,
  parameter int ROW_W       = 4
) (
  input  logic [SA_C-1:0][D_W-1:0] row_in,
  input  logic [ROW_W-1:0]         row_idx,
  input  logic [5:0]               sel_q,
  input  logic [5:0]               sel_k,
  output logic [SA_C-1:0][D_W-1:0] row_out,
  output logic [D_W-1:0]           row_max
);

  localparam logic [D_W-1:0] MIN_VAL = {1'b1, {(D_W-1){1'b0}}};

`ifndef CAUSAL_MASK_EN
  logic unused_mask_inputs;
  assign unused_mask_inputs = ^{row_idx, sel_q, sel_k};
`endif

  // Max starts at the most negative value so a fully masked row reports MIN_VAL.
  always_comb begin
    row_out = '0;
    row_max = MIN_VAL;
    for (int c = 0; c < SA_C; c++) begin
      row_out[c] = $signed(row_in[c]) >>> SCALE_SHIFT;
`ifdef CAUSAL_MASK_EN
      if ((int'(sel_k) * SA_C + c) > (int'(sel_q) * SA_R + int'(row_idx)))
        row_out[c] = MIN_VAL;
`endif
      if ($signed(row_out[c]) > $signed(row_max))
        row_max = row_out[c];
    end
  end

endmodule

// File: rtl/pipeline_scale_mask.sv
// Score-tile scale/mask stage: one tile in flight, one row per cycle. Optional causal mask via CAUSAL_MASK_EN.
module pipeline_scale_mask
  import pipeline_scale_mask_pkg::*;
#(
  parameter int D_W         = 16,
  parameter int SA_R        = 16,
  parameter int SA_C        = 16,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                               I_CLK,
  input  logic                               I_RST_N,
  input  logic                               I_VLD,
  output logic                               O_RDY,
  input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] I_MAT_S,
  input  logic [5:0]                         I_SEL_Q_O,
  input  logic [5:0]                         I_SEL_K_V,
  output logic                               O_VLD,
  input  logic                               I_RDY,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0] O_MAT_S,
  output logic [SA_R-1:0][D_W-1:0]           O_ROW_MAX,
  output logic [5:0]                         O_SEL_Q_O,
  output logic [5:0]                         O_SEL_K_V,
  output logic                               O_BUSY
);

  localparam int ROW_W = (SA_R > 1) ? $clog2(SA_R) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SA_R - 1);

  state_t                             state;
  logic [ROW_W-1:0]                   row_cnt;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] in_buf;
  logic [5:0]                         sel_q_buf;
  logic [5:0]                         sel_k_buf;
  logic [SA_C-1:0][D_W-1:0]           row_res;
  logic [D_W-1:0]                     row_max;

  row_max_scale #(
    .D_W        (D_W),
    .SA_R       (SA_R),
    .SA_C       (SA_C),
    .SCALE_SHIFT(SCALE_SHIFT),
    .ROW_W      (ROW_W)
  ) u_row_max_scale (
    .row_in (in_buf[row_cnt]),
    .row_idx(row_cnt),
    .sel_q  (sel_q_buf),
    .sel_k  (sel_k_buf),
    .row_out(row_res),
    .row_max(row_max)
  );

  // Index outputs only update when a finished tile is presented, so a reset mid-tile leaves nothing partial.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state     <= S_IDLE;
      O_RDY     <= 1'b1;
      O_VLD     <= 1'b0;
      O_BUSY    <= 1'b0;
      O_MAT_S   <= '0;
      O_ROW_MAX <= '0;
      O_SEL_Q_O <= '0;
      O_SEL_K_V <= '0;
      row_cnt   <= '0;
      in_buf    <= '0;
      sel_q_buf <= '0;
      sel_k_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_VLD) begin
            in_buf    <= I_MAT_S;
            sel_q_buf <= I_SEL_Q_O;
            sel_k_buf <= I_SEL_K_V;
            O_RDY     <= 1'b0;
            O_BUSY    <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          row_cnt <= '0;
          state   <= S_PROC;
        end
        S_PROC: begin
          O_MAT_S[row_cnt]   <= row_res;
          O_ROW_MAX[row_cnt] <= row_max;
          if (row_cnt == LAST_ROW) begin
            O_VLD     <= 1'b1;
            O_BUSY    <= 1'b0;
            O_SEL_Q_O <= sel_q_buf;
            O_SEL_K_V <= sel_k_buf;
            state     <= S_OUT;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (I_RDY) begin
            O_VLD <= 1'b0;
            O_RDY <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_scale_mask.sv
// Randomized self-checking bench for pipeline_scale_mask against an arithmetic reference model.
module tb_pipeline_scale_mask;
  import pipeline_scale_mask_pkg::*;

  localparam int D_W         = 16;
  localparam int SA_R        = 16;
  localparam int SA_C        = 16;
  localparam int SCALE_SHIFT = 2;

  typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] tile_t;
  typedef logic [SA_R-1:0][D_W-1:0]           rmax_t;

  logic       I_CLK = 1'b0;
  logic       I_RST_N;
  logic       I_VLD;
  logic       O_RDY;
  tile_t      I_MAT_S;
  logic [5:0] I_SEL_Q_O;
  logic [5:0] I_SEL_K_V;
  logic       O_VLD;
  logic       I_RDY;
  tile_t      O_MAT_S;
  rmax_t      O_ROW_MAX;
  logic [5:0] O_SEL_Q_O;
  logic [5:0] O_SEL_K_V;
  logic       O_BUSY;

  int    vectorCount = 0;
  int    missCount   = 0;
  tile_t expMat;
  rmax_t expMax;
  logic [5:0] expSelQ;
  logic [5:0] expSelK;

  pipeline_scale_mask #(
    .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VLD(I_VLD), .O_RDY(O_RDY),
    .I_MAT_S(I_MAT_S), .I_SEL_Q_O(I_SEL_Q_O), .I_SEL_K_V(I_SEL_K_V),
    .O_VLD(O_VLD), .I_RDY(I_RDY), .O_MAT_S(O_MAT_S), .O_ROW_MAX(O_ROW_MAX),
    .O_SEL_Q_O(O_SEL_Q_O), .O_SEL_K_V(O_SEL_K_V), .O_BUSY(O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int floorDiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // Reference: divide by 2^SHIFT rounding down, mask future columns, take the signed max per row.
  task automatic buildExpected(input tile_t mat, input logic [5:0] sq, input logic [5:0] sk);
    int v;
    int best;
    int gRow;
    int gCol;
    for (int r = 0; r < SA_R; r++) begin
      best = -(1 << (D_W - 1));
      for (int c = 0; c < SA_C; c++) begin
        v = floorDiv(int'($signed(mat[r][c])), 1 << SCALE_SHIFT);
        gRow = int'(sq) * SA_R + r;
        gCol = int'(sk) * SA_C + c;
`ifdef CAUSAL_MASK_EN
        if (gCol > gRow) v = -(1 << (D_W - 1));
`else
        if (gCol < 0 || gRow < 0) v = 0;
`endif
        if (v > best) best = v;
        expMat[r][c] = v[D_W-1:0];
      end
      expMax[r] = best[D_W-1:0];
    end
    expSelQ = sq;
    expSelK = sk;
  endtask

  task automatic checkTile(input string tag);
    for (int r = 0; r < SA_R; r++) begin
      for (int c = 0; c < SA_C; c++)
        checkOutput($sformatf("%s_elem_r%0d_c%0d", tag, r, c), O_MAT_S[r][c], expMat[r][c]);
      checkOutput($sformatf("%s_rowmax_r%0d", tag, r), O_ROW_MAX[r], expMax[r]);
    end
    checkOutput({tag, "_sel_q"}, O_SEL_Q_O, expSelQ);
    checkOutput({tag, "_sel_k"}, O_SEL_K_V, expSelK);
  endtask

  // Presents a tile, waits (bounded) for O_RDY, returns #1 after the accept edge.
  task automatic applyStimulus(input tile_t mat, input logic [5:0] sq, input logic [5:0] sk);
    int n;
    I_MAT_S   = mat;
    I_SEL_Q_O = sq;
    I_SEL_K_V = sk;
    I_VLD     = 1'b1;
    n = 0;
    while (!O_RDY && n < 100) begin
      @(posedge I_CLK); #1;
      n++;
    end
    checkOutput("rdy_before_accept", O_RDY, 1'b1);
    @(posedge I_CLK); #1;
    I_VLD = 1'b0;
    checkOutput("busy_after_accept", O_BUSY, 1'b1);
    checkOutput("rdy_low_after_accept", O_RDY, 1'b0);
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!O_VLD && lat < 100) begin
      @(posedge I_CLK); #1;
      lat++;
    end
    checkOutput("latency", lat, SA_R + 1);
  endtask

  task automatic runTile(input string tag, input tile_t mat, input logic [5:0] sq,
                         input logic [5:0] sk, input int holdCycles);
    int lat;
    buildExpected(mat, sq, sk);
    I_RDY = (holdCycles == 0);
    applyStimulus(mat, sq, sk);
    waitValid(lat);
    checkTile(tag);
    checkOutput({tag, "_busy_at_out"}, O_BUSY, 1'b0);
    repeat (holdCycles) begin
      @(posedge I_CLK); #1;
    end
    checkOutput({tag, "_vld_held"}, O_VLD, 1'b1);
    I_RDY = 1'b1;
    @(posedge I_CLK); #1;
    checkOutput({tag, "_vld_drop"}, O_VLD, 1'b0);
    checkOutput({tag, "_rdy_back"}, O_RDY, 1'b1);
  endtask

  function automatic tile_t fillTile(input logic [D_W-1:0] val);
    tile_t t;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        t[r][c] = val;
    return t;
  endfunction

  function automatic tile_t randTile();
    tile_t t;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        t[r][c] = D_W'($urandom);
    return t;
  endfunction

  initial begin
    tile_t tileA;
    tile_t tileB;
    int    lat;
    bit    sawVld;

    I_RST_N   = 1'b0;
    I_VLD     = 1'b0;
    I_RDY     = 1'b1;
    I_MAT_S   = '0;
    I_SEL_Q_O = '0;
    I_SEL_K_V = '0;
    #12;
    checkOutput("rst_rdy", O_RDY, 1'b1);
    checkOutput("rst_vld", O_VLD, 1'b0);
    checkOutput("rst_busy", O_BUSY, 1'b0);
    checkOutput("rst_mat_zero", O_MAT_S == '0, 1'b1);
    checkOutput("rst_rowmax_zero", O_ROW_MAX == '0, 1'b1);
    checkOutput("rst_sel", {O_SEL_Q_O, O_SEL_K_V}, 12'h000);
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    @(posedge I_CLK); #1;

    // Uniform 0x0040 tile: scaled to 0x0010.
    runTile("uniform", fillTile(16'h0040), 6'd0, 6'd0, 0);
    checkOutput("uniform_elem00_const", O_MAT_S[0][0], 16'h0010);
    checkOutput("uniform_rowmax0_const", O_ROW_MAX[0], 16'h0010);
`ifdef CAUSAL_MASK_EN
    checkOutput("uniform_elem01_masked", O_MAT_S[0][1], MASK_VAL);
`else
    checkOutput("uniform_elem01_const", O_MAT_S[0][1], 16'h0010);
`endif

    // Negative rounding and a -8..7 row.
    tileA = fillTile(16'h0000);
    for (int c = 0; c < SA_C; c++) tileA[0][c] = D_W'(c - 8);
    tileA[1][0] = 16'hFFFD;
    runTile("negative", tileA, 6'd0, 6'd0, 0);
    checkOutput("neg3_scaled", O_MAT_S[1][0], 16'hFFFF);
`ifdef CAUSAL_MASK_EN
    checkOutput("row_m8_7_max", O_ROW_MAX[0], 16'hFFFE);
`else
    checkOutput("row_m8_7_max", O_ROW_MAX[0], 16'h0001);
`endif

    // Key block ahead of query block: fully masked when the mask is enabled.
    runTile("future_block", fillTile(16'h0040), 6'd0, 6'd1, 2);
`ifdef CAUSAL_MASK_EN
    checkOutput("future_rowmax15", O_ROW_MAX[SA_R-1], MASK_VAL);
`else
    checkOutput("future_rowmax15", O_ROW_MAX[SA_R-1], 16'h0010);
`endif

    for (int t = 0; t < 6; t++)
      runTile($sformatf("rand%0d", t), randTile(),
              6'($urandom_range(0, 2)), 6'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    // Back-pressure: 10 cycles of I_RDY low, second tile waiting on I_VLD.
    tileA = randTile();
    tileB = randTile();
    buildExpected(tileA, 6'd1, 6'd0);
    I_RDY = 1'b0;
    applyStimulus(tileA, 6'd1, 6'd0);
    waitValid(lat);
    I_MAT_S   = tileB;
    I_SEL_Q_O = 6'd2;
    I_SEL_K_V = 6'd1;
    I_VLD     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_vld_c%0d", i), O_VLD, 1'b1);
      checkOutput($sformatf("bp_rdy_c%0d", i), O_RDY, 1'b0);
      checkOutput($sformatf("bp_busy_c%0d", i), O_BUSY, 1'b0);
      checkOutput($sformatf("bp_mat_hold_c%0d", i), O_MAT_S == expMat, 1'b1);
      checkOutput($sformatf("bp_max_hold_c%0d", i), O_ROW_MAX == expMax, 1'b1);
      @(posedge I_CLK); #1;
    end
    I_RDY = 1'b1;
    @(posedge I_CLK); #1;
    checkOutput("bp_transfer_vld", O_VLD, 1'b0);
    checkOutput("bp_transfer_rdy", O_RDY, 1'b1);
    checkOutput("bp_not_yet_accepted", O_BUSY, 1'b0);
    checkOutput("bp_retain_mat", O_MAT_S == expMat, 1'b1);
    checkOutput("bp_retain_sel", O_SEL_Q_O, 6'd1);
    buildExpected(tileB, 6'd2, 6'd1);
    @(posedge I_CLK); #1;
    I_VLD = 1'b0;
    checkOutput("bp_second_accepted", O_BUSY, 1'b1);
    waitValid(lat);
    checkTile("bp_second");
    @(posedge I_CLK); #1;

    // Reset while processing row 7: tile discarded.
    I_RDY = 1'b1;
    applyStimulus(randTile(), 6'd0, 6'd0);
    repeat (8) @(posedge I_CLK);
    #2;
    I_RST_N = 1'b0;
    #1;
    checkOutput("midrst_rdy", O_RDY, 1'b1);
    checkOutput("midrst_vld", O_VLD, 1'b0);
    checkOutput("midrst_busy", O_BUSY, 1'b0);
    checkOutput("midrst_mat_zero", O_MAT_S == '0, 1'b1);
    checkOutput("midrst_max_zero", O_ROW_MAX == '0, 1'b1);
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
    sawVld = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge I_CLK); #1;
      if (O_VLD) sawVld = 1'b1;
    end
    checkOutput("midrst_no_vld", sawVld, 1'b0);
    checkOutput("midrst_rdy_after", O_RDY, 1'b1);
    runTile("after_rst", randTile(), 6'd1, 6'd1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipeline_scale_mask.md
PIPELINE_SCALE_MASK -- requirements
Module: pipeline_scale_mask

Interface
REQ-001 Parameter D_W, default 16, signed fixed-point element width.
REQ-002 Parameter SA_R, default 16, tile rows.
REQ-003 Parameter SA_C, default 16, tile columns.
REQ-004 Parameter SCALE_SHIFT, default 2, arithmetic right-shift implementing 1/sqrt(d_k).
REQ-005 I_CLK  in  1  sole clock, rising edge.
REQ-006 I_RST_N  in  1  asynchronous active-low reset.
REQ-007 I_VLD  in  1  upstream score tile valid (from Q*K^T stage O_VLD).
REQ-008 O_RDY  out  1  stage can accept a tile (to Q*K^T stage I_RDY).
REQ-009 I_MAT_S  in  D_W x [SA_R][SA_C]  raw score tile S.
REQ-010 I_SEL_Q_O / I_SEL_K_V  in  6 each  Q row-block and K row-block indices of the tile.
REQ-011 O_VLD  out  1  processed tile valid.
REQ-012 I_RDY  in  1  downstream ready.
REQ-013 O_MAT_S  out  D_W x [SA_R][SA_C]  scaled/masked tile.
REQ-014 O_ROW_MAX  out  D_W x [SA_R]  per-row signed maximum of O_MAT_S.
REQ-015 O_SEL_Q_O / O_SEL_K_V  out  6 each  indices travelling with the tile.
REQ-016 O_BUSY  out  1  high in S_LOAD and S_PROC.

Function
REQ-017 FSM states S_IDLE, S_LOAD, S_PROC, S_OUT; exactly one tile in flight.
REQ-018 O_RDY SHALL be high only in S_IDLE; accept on edge with I_VLD & O_RDY; S_IDLE->S_LOAD.
REQ-019 S_LOAD SHALL register I_MAT_S and sel indices (sampled at accept edge), clear row counter, go to S_PROC next edge.
REQ-020 S_PROC SHALL process one row per cycle, row r = counter 0..SA_R-1, writing SA_C results and O_ROW_MAX[r] in place.
REQ-021 Element result = input >>> SCALE_SHIFT (arithmetic, round toward minus infinity), width D_W.
REQ-022 Row max = signed compare over the row's SA_C results, combinational within the row cycle.
REQ-023 After row SA_R-1, state->S_OUT, O_VLD high, O_BUSY low; accept-to-O_VLD latency = SA_R+1 cycles.
REQ-024 O_VLD, O_MAT_S, O_ROW_MAX, sel outputs SHALL hold stable while O_VLD & !I_RDY.
REQ-025 On O_VLD & I_RDY edge: O_VLD low, state->S_IDLE, O_RDY high next cycle; outputs retain last values.
REQ-026 I_VLD outside S_IDLE SHALL be ignored; upstream holds its tile until O_RDY.
REQ-027 Row counter SHALL not wrap; terminal value SA_R-1 forces exit from S_PROC.

Reset
REQ-028 On I_RST_N low, immediately: state S_IDLE, O_RDY 1, O_VLD 0, O_BUSY 0, O_MAT_S 0, O_ROW_MAX 0, sel outputs 0, counter 0.
REQ-029 Reset mid-S_PROC or mid-S_OUT SHALL discard the tile; no partial output after release.

Configuration
REQ-030 Macro CAUSAL_MASK_EN defined: element (r,c) with global column sel_k*SA_C+c > global row sel_q*SA_R+r SHALL become -2^(D_W-1) (0x8000 for D_W=16) after scaling.
REQ-031 Fully masked row SHALL give O_ROW_MAX[r] = -2^(D_W-1).
REQ-032 Macro undefined: no masking logic; results are scaled values only.

Structure
REQ-033 Shared package holds FSM state enum and MASK_VAL constant (-2^(D_W-1) at D_W=16).
REQ-034 One sub-module row_max_scale: one row in, scaled/masked row and max out, combinational; instantiated once.

Verification
REQ-035 All elements 0x0040, SHIFT 2, sel 0/0, I_RDY=1 -> all outputs 0x0010, row max 0x0010, O_VLD exactly 17 cycles after accept.
REQ-036 Element 0xFFFD (-3) -> 0xFFFF (-1); row with values -8..7 -> max 0x0001.
REQ-037 CAUSAL_MASK_EN, sel_q=0, sel_k=0, all 0x0040 -> strict upper triangle 0x8000, diagonal/below 0x0010; row 0 max 0x0010.
REQ-038 CAUSAL_MASK_EN, sel_q=0, sel_k=1 -> whole tile 0x8000, every O_ROW_MAX 0x8000; without macro -> all 0x0010.
REQ-039 I_RDY low 10 cycles after O_VLD -> outputs stable, O_RDY low, second I_VLD tile not accepted until one cycle after transfer.
REQ-040 Reset asserted at row 7 of S_PROC -> O_VLD never rises, O_RDY 1 after release, next tile processes correctly.
